// File: rtl/microseq_pkg.sv
// Shared constants and types for the CU microstore sequencer.
package microseq_pkg;

    localparam int unsigned AW_DEF = 7;
    localparam int unsigned DW_DEF = 45;

    localparam int unsigned NS_HI  = 9;
    localparam int unsigned NS_LO  = 7;
    localparam int unsigned CRA_HI = 6;
    localparam int unsigned CRA_LO = 0;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        INC      = 3'd2,
        JUMP     = 3'd3,
        JCOND    = 3'd4,
        WAIT_MOC = 3'd5,
        CALL     = 3'd6,
        RET      = 3'd7
    } ns_op_e;

    localparam logic [6:0] ABORT_ADDR_DEF = 7'h5C;
    localparam logic [6:0] IRQ_ADDR_DEF   = 7'h51;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for microsubroutines; refuses writes when full and pops when empty.
module useq_stack #(
    parameter int unsigned AW          = 7,
    parameter int unsigned STACK_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_mem [STACK_DEPTH];

    assign full  = (r_sp == SPW'(STACK_DEPTH));
    assign empty = (r_sp == '0);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (SPW'(i + 1) == r_sp) dout = r_mem[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
        end else if (push && !full) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (SPW'(i) == r_sp) r_mem[i] <= din;
            end
            r_sp <= r_sp + SPW'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Micro-PC next-address sequencer with control register, return stack and MOC watchdog.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int unsigned   AW          = AW_DEF,
    parameter int unsigned   DW          = DW_DEF,
    parameter int unsigned   STACK_DEPTH = 2,
    parameter int unsigned   MOC_TIMEOUT = 255,
    parameter logic [AW-1:0] ABORT_ADDR  = AW'(ABORT_ADDR_DEF),
    parameter logic [AW-1:0] IRQ_ADDR    = AW'(IRQ_ADDR_DEF)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    output logic [AW-1:0] rom_index,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] cr,
    input  logic [AW-1:0] dec_addr,
    input  logic          cond,
    input  logic          moc,
    input  logic          irq,
    output logic          waiting,
    output logic          moc_abort,
    output logic          stack_err
);

    localparam int unsigned WW      = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
    localparam bit          WDOG_EN = (MOC_TIMEOUT != 0);

    logic [AW-1:0] r_upc;
    logic [DW-1:0] r_cr;
    logic [WW-1:0] r_wdog;
    logic          r_abort;
    logic          r_err;

    ns_op_e        w_op;
    logic [AW-1:0] w_cr_addr;
    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_next;
    logic [AW-1:0] w_top;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_expire;
    logic          w_hold;

    assign w_op      = ns_op_e'(rom_data[NS_HI:NS_LO]);
    assign w_cr_addr = AW'(rom_data[CRA_HI:CRA_LO]);
    assign w_inc     = r_upc + AW'(1);
    assign w_hold    = (w_op == WAIT_MOC) && !moc;
    assign w_expire  = WDOG_EN && w_hold && (r_wdog == WW'(MOC_TIMEOUT - 1));

    always_comb begin
        w_next = w_inc;
        w_push = 1'b0;
        w_pop  = 1'b0;
        case (w_op)
            FETCH:    w_next = irq ? IRQ_ADDR : '0;
            DECODE:   w_next = dec_addr;
            INC:      w_next = w_inc;
            JUMP:     w_next = w_cr_addr;
            JCOND:    w_next = cond ? w_cr_addr : w_inc;
            WAIT_MOC: w_next = moc ? w_inc : (w_expire ? ABORT_ADDR : r_upc);
            CALL: begin
                w_push = !stall;
                w_next = w_cr_addr;
            end
            RET: begin
                w_pop  = !stall;
                w_next = w_empty ? '0 : w_top;
            end
            default:  w_next = w_inc;
        endcase
    end

    useq_stack #(
        .AW          (AW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_inc),
        .dout    (w_top),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_upc   <= '0;
            r_cr    <= '0;
            r_wdog  <= '0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else if (stall) begin
            r_abort <= 1'b0;
        end else begin
            r_upc   <= w_next;
            r_cr    <= rom_data;
            r_abort <= w_expire;
            // Counter restarts after expiry so a re-entered wait gets a full timeout.
            r_wdog  <= (WDOG_EN && w_hold && !w_expire) ? r_wdog + WW'(1) : '0;
            if ((w_push && w_full) || (w_pop && w_empty)) r_err <= 1'b1;
        end
    end

    assign rom_index = r_upc;
    assign cr        = r_cr;
    assign waiting   = w_hold;
    assign moc_abort = r_abort;
    assign stack_err = r_err;

endmodule
